// File: rtl/ddr3_frame_rd_sched.sv
// Frame-slot ring for DDR3 JPEG frames: hands free slots to the encoder and launches one
// read/UDP transfer per queued frame, one at a time. The slot is released after completion or timeout.
module ddr3_frame_rd_sched #(
  parameter int          DEPTH       = 4,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] SLOT_STRIDE = 24'h020000,
  parameter int          START_TMO   = 16,
  parameter logic [23:0] RUN_TMO     = 24'd8_000_000
) (
  input  logic        i_pclk84m,
  input  logic        i_rst,
  input  logic        i_pause,
  input  logic        i_wr_frame_done,
  input  logic [24:0] i_wr_frame_len,
  output logic [23:0] o_wr_slot_addr,
  output logic        o_wr_ready,
  output logic        o_rd_en,
  output logic [23:0] o_rd_addr,
  output logic [24:0] o_rd_byte_len,
  input  logic        i_rd_busy,
  output logic [15:0] o_frame_seq,
  output logic [15:0] o_drop_cnt,
  output logic        o_timeout,
  output logic [4:0]  o_level
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RELEASE} state_t;

  function automatic logic [23:0] slot_addr(input logic [PW-1:0] ptr);
    return BASE_ADDR + 24'(ptr) * SLOT_STRIDE;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          wr_ready_q, wr_ready_d;
  logic [23:0]   timer_q, timer_d;
  logic          rd_en_q, rd_en_d;
  logic [23:0]   rd_addr_q, rd_addr_d;
  logic [24:0]   rd_len_q, rd_len_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   drop_q, drop_d;
  logic          tmo_q, tmo_d;
  logic [24:0]   len_mem_q [DEPTH];

  logic push_vld, pop, full, push_acc;

  assign push_vld = i_wr_frame_done && (i_wr_frame_len != 25'd0);
  assign pop      = (state_q == S_RELEASE);
  assign full     = (count_q == 5'(DEPTH));
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push_acc = push_vld && (!full || pop);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    timer_d    = timer_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    tmo_d      = 1'b0;

    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_vld && full && !pop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    count_d    = count_q + {4'd0, push_acc} - {4'd0, pop};
    wr_ready_d = (count_d < 5'(DEPTH));

    case (state_q)
      S_IDLE: begin
        if ((count_q != 5'd0) && !i_pause && !i_rd_busy) begin
          rd_addr_d = slot_addr(rd_ptr_q);
          rd_len_d  = len_mem_q[rd_ptr_q];
          rd_en_d   = 1'b1;
          timer_d   = 24'd0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = timer_q + 24'd1;
        if (i_rd_busy) begin
          rd_en_d = 1'b0;
          timer_d = 24'd0;
          state_d = S_RUN;
        end else if (timer_q == 24'(START_TMO - 1)) begin
          rd_en_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RUN: begin
        timer_d = timer_q + 24'd1;
        if (!i_rd_busy) begin
          state_d = S_RELEASE;
        end else if (timer_q == RUN_TMO - 24'd1) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      default: begin
        seq_d   = seq_q + 16'd1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_pclk84m or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      wr_ready_q <= 1'b1;
      timer_q    <= 24'd0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 24'd0;
      rd_len_q   <= 25'd0;
      seq_q      <= 16'd0;
      drop_q     <= 16'd0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      timer_q    <= timer_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
    end
  end

  // Slot addresses derive from the pointer, so only lengths need storage.
  always_ff @(posedge i_pclk84m) begin
    if (push_acc) len_mem_q[wr_ptr_q] <= i_wr_frame_len;
  end

  assign o_wr_slot_addr = slot_addr(wr_ptr_q);
  assign o_wr_ready     = wr_ready_q;
  assign o_rd_en        = rd_en_q;
  assign o_rd_addr      = rd_addr_q;
  assign o_rd_byte_len  = rd_len_q;
  assign o_frame_seq    = seq_q;
  assign o_drop_cnt     = drop_q;
  assign o_timeout      = tmo_q;
  assign o_level        = count_q;

endmodule

// File: tb/tb_ddr3_frame_rd_sched.sv
// Directed bench for ddr3_frame_rd_sched: inputs driven and outputs sampled on the falling edge.
module tb_ddr3_frame_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        wr_done;
  logic [24:0] wr_len;
  logic [23:0] wr_slot_addr;
  logic        wr_ready;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [24:0] rd_len;
  logic        rd_busy;
  logic [15:0] frame_seq;
  logic [15:0] drop_cnt;
  logic        timeout;
  logic [4:0]  level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr3_frame_rd_sched dut (
    .i_pclk84m       (clk),
    .i_rst           (rst),
    .i_pause         (pause),
    .i_wr_frame_done (wr_done),
    .i_wr_frame_len  (wr_len),
    .o_wr_slot_addr  (wr_slot_addr),
    .o_wr_ready      (wr_ready),
    .o_rd_en         (rd_en),
    .o_rd_addr       (rd_addr),
    .o_rd_byte_len   (rd_len),
    .i_rd_busy       (rd_busy),
    .o_frame_seq     (frame_seq),
    .o_drop_cnt      (drop_cnt),
    .o_timeout       (timeout),
    .o_level         (level)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pause = 1'b0; wr_done = 1'b0; wr_len = '0; rd_busy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [24:0] len);
    wr_done = 1'b1; wr_len = len;
    step();
    wr_done = 1'b0; wr_len = '0;
  endtask

  task automatic wait_rd_en(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (rd_en) break;
      step();
    end
    check_eq(tag, 32'(rd_en), 32'd1);
  endtask

  // Acts as the read master up to the RELEASE cycle of the launched frame.
  task automatic serve_to_release(input string tag, input logic [23:0] exp_addr,
                                  input logic [24:0] exp_len);
    wait_rd_en({tag, "_rd_en"});
    check_eq({tag, "_addr"}, 32'(rd_addr), 32'(exp_addr));
    check_eq({tag, "_len"}, 32'(rd_len), 32'(exp_len));
    rd_busy = 1'b1;
    step();
    check_eq({tag, "_en_drop"}, 32'(rd_en), 32'd0);
    rd_busy = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int tmo_cnt;

    // Reset state
    do_reset();
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_rd_len", 32'(rd_len), 32'd0);
    check_eq("rst_seq", 32'(frame_seq), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("rst_tmo", 32'(timeout), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_slot", 32'(wr_slot_addr), 32'h000000);

    // Single frame
    push(25'd1456);
    check_eq("t1_no_early_en", 32'(rd_en), 32'd0);
    step();
    check_eq("t1_rd_en", 32'(rd_en), 32'd1);
    check_eq("t1_addr", 32'(rd_addr), 32'h000000);
    check_eq("t1_len", 32'(rd_len), 32'd1456);
    check_eq("t1_next_slot", 32'(wr_slot_addr), 32'h020000);
    step(); step();
    rd_busy = 1'b1;
    step();
    check_eq("t1_en_low_run", 32'(rd_en), 32'd0);
    repeat (99) step();
    check_eq("t1_seq_running", 32'(frame_seq), 32'd0);
    rd_busy = 1'b0;
    step();
    check_eq("t1_tmo_release", 32'(timeout), 32'd0);
    step();
    check_eq("t1_seq", 32'(frame_seq), 32'd1);
    check_eq("t1_level", 32'(level), 32'd0);

    // Fill and overflow
    do_reset();
    rd_busy = 1'b1;
    check_eq("t2_slot0", 32'(wr_slot_addr), 32'h000000);
    push(25'd100);
    check_eq("t2_slot1", 32'(wr_slot_addr), 32'h020000);
    push(25'd101);
    check_eq("t2_slot2", 32'(wr_slot_addr), 32'h040000);
    push(25'd102);
    check_eq("t2_slot3", 32'(wr_slot_addr), 32'h060000);
    push(25'd103);
    check_eq("t2_slot_wrap", 32'(wr_slot_addr), 32'h000000);
    push(25'd104);
    push(25'd105);
    check_eq("t2_level", 32'(level), 32'd4);
    check_eq("t2_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("t2_drop", 32'(drop_cnt), 32'd2);
    check_eq("t2_no_launch", 32'(rd_en), 32'd0);
    rd_busy = 1'b0;
    serve_to_release("t2_f0", 24'h000000, 25'd100);
    step();
    serve_to_release("t2_f1", 24'h020000, 25'd101);
    step();
    serve_to_release("t2_f2", 24'h040000, 25'd102);
    step();
    serve_to_release("t2_f3", 24'h060000, 25'd103);
    step();
    check_eq("t2_seq", 32'(frame_seq), 32'd4);
    check_eq("t2_level_end", 32'(level), 32'd0);
    check_eq("t2_wr_ready_end", 32'(wr_ready), 32'd1);

    // Push on the RELEASE cycle of a full queue
    do_reset();
    rd_busy = 1'b1;
    push(25'd200); push(25'd201); push(25'd202); push(25'd203);
    check_eq("t3_full", 32'(level), 32'd4);
    rd_busy = 1'b0;
    serve_to_release("t3_f0", 24'h000000, 25'd200);
    push(25'd204);
    check_eq("t3_drop", 32'(drop_cnt), 32'd0);
    check_eq("t3_level", 32'(level), 32'd4);
    check_eq("t3_slot", 32'(wr_slot_addr), 32'h020000);
    check_eq("t3_seq", 32'(frame_seq), 32'd1);
    check_eq("t3_wr_ready", 32'(wr_ready), 32'd0);

    // Start timeout
    do_reset();
    push(25'd50);
    en_cnt = 0;
    tmo_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rd_en) en_cnt++;
      if (timeout) tmo_cnt++;
    end
    check_eq("t4_en_cycles", 32'(en_cnt), 32'd16);
    check_eq("t4_tmo_pulses", 32'(tmo_cnt), 32'd1);
    check_eq("t4_seq", 32'(frame_seq), 32'd1);
    check_eq("t4_level", 32'(level), 32'd0);

    // Pause and zero-length frame
    do_reset();
    pause = 1'b1;
    push(25'd0);
    check_eq("t5_zero_ignored", 32'(level), 32'd0);
    push(25'd64);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_en) en_cnt++;
    end
    check_eq("t5_paused_en", 32'(en_cnt), 32'd0);
    check_eq("t5_level", 32'(level), 32'd1);
    pause = 1'b0;
    step();
    check_eq("t5_launch", 32'(rd_en), 32'd1);
    check_eq("t5_len", 32'(rd_len), 32'd64);
    check_eq("t5_addr", 32'(rd_addr), 32'h000000);
    rd_busy = 1'b1;
    step();
    rd_busy = 1'b0;
    step(); step();
    check_eq("t5_seq", 32'(frame_seq), 32'd1);

    // Async reset mid-RUN
    push(25'd10);
    step();
    check_eq("t6_launch", 32'(rd_en), 32'd1);
    check_eq("t6_addr", 32'(rd_addr), 32'h020000);
    rd_busy = 1'b1;
    push(25'd20);
    check_eq("t6_level_pre", 32'(level), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rd_en", 32'(rd_en), 32'd0);
    check_eq("t6_level", 32'(level), 32'd0);
    check_eq("t6_seq", 32'(frame_seq), 32'd0);
    check_eq("t6_slot", 32'(wr_slot_addr), 32'h000000);
    check_eq("t6_rd_addr", 32'(rd_addr), 32'd0);
    rd_busy = 1'b0;
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
